multdiv_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide unit. It sits beside the ALU adder stage in the execute path and consumes the 32-bit carry-lookahead adder as its per-cycle add/sub engine.
- The processor issues a one-cycle start pulse with operands, stalls, and collects the result on a one-cycle ready pulse.
- Used for MIDI pitch/envelope scaling (mul) and tempo/period math (div).

---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/booth_recode.sv | 22 ++
 rtl/multdiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants and encodings for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int MULT_ITERS   = 16;
    localparam int DIV_ITERS    = 32;
    localparam int MULT_LATENCY = 17;
    localparam int DIV_LATENCY  = 34;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_MULT    = 3'd1;
    localparam state_t ST_DIV     = 3'd2;
    localparam state_t ST_DIV_FIX = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        BS_ZERO,
        BS_PA,
        BS_P2A,
        BS_NA,
        BS_N2A
    } booth_sel_e;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier window to partial-product select.
module booth_recode
    import multdiv_pkg::*;
(
    input  logic [2:0] window_i,
    output booth_sel_e sel_o,
    output logic       neg_o
);

    always_comb begin
        unique case (window_i)
            3'b001, 3'b010: sel_o = BS_PA;
            3'b011:         sel_o = BS_P2A;
            3'b100:         sel_o = BS_N2A;
            3'b101, 3'b110: sel_o = BS_NA;
            default:        sel_o = BS_ZERO;
        endcase
    end

    assign neg_o = (sel_o == BS_NA) || (sel_o == BS_N2A);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (non-restoring)
// built around one shared CLA add/sub datapath.
//   state      | meaning
//   ST_IDLE    | waiting for a start pulse
//   ST_MULT    | Booth iterations, one per edge
//   ST_DIV     | non-restoring divide iterations on |A| with signed B
//   ST_DIV_FIX | negate quotient when operand signs differ
//   ST_DONE    | register result/exception, pulse RDY
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    if (WIDTH != 32 || MULT_ITERS != WIDTH / 2 || DIV_ITERS != WIDTH ||
        MULT_LATENCY != MULT_ITERS + 1 || DIV_LATENCY != DIV_ITERS + 2) begin : g_cfg_check
        $error("multdiv_unit: only WIDTH=32 is supported");
    end

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d, res_q, res_d;
    logic [WIDTH+1:0] hi_q, hi_d;
    logic             ext_q, ext_d, exc_q, exc_d, rdy_q, rdy_d;

    logic       start_mul, start_div;
    booth_sel_e sel;
    logic       sel_neg;

    logic [WIDTH+1:0] add_x, add_y, add_y_eff, add_sum, rem_shl;
    logic             add_sub, ext_c;
    logic [WIDTH/4:0] grp_c;
    logic [3:0]       bit_p, bit_g, bit_c;

    logic [WIDTH:0]   ovf_bits;
    logic             mul_ovf, div_by_zero, div_ovf;

    assign start_mul = ctrl_MULT;
    assign start_div = ctrl_DIV & ~ctrl_MULT;

    booth_recode u_booth (
        .window_i ({lo_q[1:0], ext_q}),
        .sel_o    (sel),
        .neg_o    (sel_neg)
    );

    // Partial remainder stays within +/-2^31, so bit 31 already carries its sign.
    assign rem_shl = {hi_q[WIDTH-1], hi_q[WIDTH-1:0], lo_q[WIDTH-1]};

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        if (start_div) begin
            add_y   = {{2{data_operandA[WIDTH-1]}}, data_operandA};
            add_sub = data_operandA[WIDTH-1];
        end else if (state_q == ST_MULT) begin
            add_x   = hi_q;
            add_sub = sel_neg;
            unique case (sel)
                BS_PA, BS_NA:   add_y = {{2{a_q[WIDTH-1]}}, a_q};
                BS_P2A, BS_N2A: add_y = {a_q[WIDTH-1], a_q, 1'b0};
                default:        add_y = '0;
            endcase
        end else if (state_q == ST_DIV) begin
            add_x   = rem_shl;
            add_y   = {{2{b_q[WIDTH-1]}}, b_q};
            add_sub = ~hi_q[WIDTH] ^ b_q[WIDTH-1];
        end else if (state_q == ST_DIV_FIX) begin
            add_y   = {2'b00, lo_q};
            add_sub = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        end
    end

    // 4-bit lookahead groups for the low word, full-adder chain for the two extension bits.
    always_comb begin
        add_y_eff = add_sub ? ~add_y : add_y;
        add_sum   = '0;
        grp_c     = '0;
        grp_c[0]  = add_sub;
        bit_p     = '0;
        bit_g     = '0;
        bit_c     = '0;
        for (int k = 0; k < WIDTH / 4; k++) begin
            bit_p = add_x[4*k +: 4] ^ add_y_eff[4*k +: 4];
            bit_g = add_x[4*k +: 4] & add_y_eff[4*k +: 4];
            bit_c[0] = grp_c[k];
            bit_c[1] = bit_g[0] | (bit_p[0] & grp_c[k]);
            bit_c[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & grp_c[k]);
            bit_c[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
                     | (bit_p[2] & bit_p[1] & bit_p[0] & grp_c[k]);
            grp_c[k+1] = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
                       | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]) | (&bit_p & grp_c[k]);
            add_sum[4*k +: 4] = bit_p ^ bit_c;
        end
        add_sum[WIDTH] = add_x[WIDTH] ^ add_y_eff[WIDTH] ^ grp_c[WIDTH/4];
        ext_c = (add_x[WIDTH] & add_y_eff[WIDTH]) |
                (grp_c[WIDTH/4] & (add_x[WIDTH] ^ add_y_eff[WIDTH]));
        add_sum[WIDTH+1] = add_x[WIDTH+1] ^ add_y_eff[WIDTH+1] ^ ext_c;
    end

    assign ovf_bits    = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign mul_ovf     = ~((&ovf_bits) | ~(|ovf_bits));
    assign div_by_zero = (b_q == '0);
    assign div_ovf     = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ext_d    = ext_q;
        res_d    = res_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (start_mul || start_div) begin
            a_d      = data_operandA;
            b_d      = data_operandB;
            hi_d     = '0;
            ext_d    = 1'b0;
            op_div_d = start_div;
            if (start_mul) begin
                state_d = ST_MULT;
                cnt_d   = 6'(MULT_ITERS - 1);
                lo_d    = data_operandB;
            end else begin
                state_d = ST_DIV;
                cnt_d   = 6'(DIV_ITERS - 1);
                lo_d    = add_sum[WIDTH-1:0];
            end
        end else begin
            unique case (state_q)
                ST_MULT: begin
                    hi_d  = {{2{add_sum[WIDTH+1]}}, add_sum[WIDTH+1:2]};
                    lo_d  = {add_sum[1:0], lo_q[WIDTH-1:2]};
                    ext_d = lo_q[1];
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == '0) state_d = ST_DONE;
                end
                ST_DIV: begin
                    hi_d  = add_sum;
                    lo_d  = {lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == '0) state_d = ST_DIV_FIX;
                end
                ST_DIV_FIX: begin
                    lo_d    = add_sum[WIDTH-1:0];
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                    if (op_div_q) begin
                        res_d = div_by_zero ? '0 : lo_q;
                        exc_d = div_by_zero | div_ovf;
                    end else begin
                        res_d = lo_q;
                        exc_d = mul_ovf;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ext_q    <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ext_q    <= ext_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases, aborts, reset and
// random operands against a 64-bit arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_r = '0;

    always #5 clock = ~clock;

    multdiv_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // op: 0 multiply, 1 divide, 2 both start lines high (multiply)
    function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint pa, pb, v;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (op != 1) begin
            v = pa * pb;
        end else if (b == 32'd0) begin
            v = 0;
        end else begin
            v = pa / pb;
        end
        r = v[31:0];
        e = (op == 1 && b == 32'd0) || (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    task automatic start_op(input int op, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = (op != 1);
        ctrl_DIV  = (op != 0);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_r,
                             input logic exp_e);
        int lat = 0;
        int busy_gaps = 0;
        check({tag, "/hold"}, data_result, last_r);
        if (data_resultRDY !== 1'b0 || busy !== 1'b1) busy_gaps++;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_gaps++;
                break;
            end
            if (busy !== 1'b1) busy_gaps++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/busy"}, 32'(busy_gaps), 32'd0);
        check({tag, "/result"}, data_result, exp_r);
        check({tag, "/exception"}, 32'(data_exception), 32'(exp_e));
        last_r = exp_r;
        @(negedge clock);
        check({tag, "/rdy_drop"}, 32'({data_resultRDY, busy}), 32'd0);
    endtask

    task automatic do_op(input string tag, input int op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        model(op, a, b, r, e);
        start_op(op, a, b);
        wait_done(tag, (op == 1) ? 34 : 17, r, e);
    endtask

    initial begin
        int          stray;
        int          op;
        int          mode;
        logic [31:0] ra, rb;

        #1 reset_n = 1'b0;
        #1;
        check("rst/result", data_result, 32'd0);
        check("rst/exc_rdy_busy", 32'({data_exception, data_resultRDY, busy}), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        do_op("mul_7x-3", 0, 32'h0000_0007, 32'hFFFF_FFFD);
        check("mul_7x-3/value", last_r, 32'hFFFF_FFEB);
        do_op("mul_ovf", 0, 32'h0001_0000, 32'h0001_0000);
        do_op("mul_max", 0, 32'h7FFF_FFFF, 32'h0000_0001);
        do_op("mul_min_sq", 0, 32'h8000_0000, 32'h8000_0000);
        do_op("mul_neg1_min", 0, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("div_-7/2", 1, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_-7/2/value", last_r, 32'hFFFF_FFFD);
        do_op("div_100/-7", 1, 32'd100, 32'hFFFF_FFF9);
        do_op("div_by_0", 1, 32'd5, 32'd0);
        do_op("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_min/1", 1, 32'h8000_0000, 32'h0000_0001);

        // A multiply aborted by a divide started on its fifth edge.
        start_op(0, 32'd3, 32'd4);
        stray = 0;
        repeat (4) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) stray++;
        end
        check("abort/no_rdy", 32'(stray), 32'd0);
        start_op(1, 32'd100, 32'd7);
        wait_done("abort_div", 34, 32'd14, 1'b0);

        do_op("both_6x2", 2, 32'd6, 32'd2);
        check("both_6x2/value", last_r, 32'd12);

        for (int i = 0; i < 24; i++) begin
            op   = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            if (mode == 1) begin
                ra = 32'($urandom_range(0, 200000)) - 32'd100000;
                rb = 32'($urandom_range(0, 64)) - 32'd32;
            end else if (mode == 2 && op == 1) begin
                rb = 32'd0;
            end
            do_op($sformatf("rand%0d", i), op, ra, rb);
        end

        // Asynchronous reset in the middle of a multiply.
        start_op(0, 32'd3, 32'd5);
        repeat (7) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst/result", data_result, 32'd0);
        check("midrst/exc_rdy_busy", 32'({data_exception, data_resultRDY, busy}), 32'd0);
        last_r = 32'd0;
        @(negedge clock);
        reset_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) stray++;
        end
        check("midrst/no_rdy", 32'(stray), 32'd0);
        do_op("post_rst_2x2", 0, 32'd2, 32'd2);
        check("post_rst_2x2/value", last_r, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
